// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - program counter and handshaked instruction fetch sequencer
// Fetches one instruction at a time, holds it until the core retires it, then advances or redirects.
module fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0004,
  parameter int unsigned TIMEOUT      = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        retire,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        misalign_trap,
  output logic        fetch_err,
  output logic [31:0] instret
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_TRAP = 2'd3;

  logic [1:0]    r_state;
  logic [31:0]   r_pc;
  logic [31:0]   r_instr;
  logic [31:0]   r_instr_pc;
  logic [31:0]   r_instret;
  logic [CW-1:0] r_cnt;
  logic          r_misalign;
  logic          r_fetch_err;

  logic w_timeout;
  logic w_misaligned;

  assign w_timeout    = (r_cnt == CNT_LAST);
  assign w_misaligned = (redirect_target[1:0] != 2'b00);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_VECTOR;
      r_instr     <= 32'd0;
      r_instr_pc  <= 32'd0;
      r_instret   <= 32'd0;
      r_cnt       <= '0;
      r_misalign  <= 1'b0;
      r_fetch_err <= 1'b0;
    end else begin
      // Trap causes are single-cycle pulses that coincide with the TRAP state.
      r_misalign  <= 1'b0;
      r_fetch_err <= 1'b0;
      case (r_state)
        S_IDLE: r_state <= S_REQ;
        S_REQ: begin
          // An ack on the last allowed cycle still wins over the timeout.
          if (imem_ack) begin
            r_instr    <= imem_rdata;
            r_instr_pc <= r_pc;
            r_cnt      <= '0;
            r_state    <= S_HOLD;
          end else if (w_timeout) begin
            r_fetch_err <= 1'b1;
            r_pc        <= TRAP_VECTOR;
            r_cnt       <= '0;
            r_state     <= S_TRAP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_HOLD: begin
          if (retire) begin
            r_instret <= r_instret + 32'd1;
            if (redirect && w_misaligned) begin
              r_misalign <= 1'b1;
              r_pc       <= TRAP_VECTOR;
              r_state    <= S_TRAP;
            end else begin
              r_pc    <= redirect ? redirect_target : r_pc + 32'd4;
              r_state <= S_REQ;
            end
          end
        end
        S_TRAP:  r_state <= S_REQ;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign imem_req      = (r_state == S_REQ);
  assign imem_addr     = r_pc;
  assign instr_valid   = (r_state == S_HOLD);
  assign instr         = r_instr;
  assign instr_pc      = r_instr_pc;
  assign instret       = r_instret;
  assign misalign_trap = r_misalign;
  assign fetch_err     = r_fetch_err;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - self-checking bench for fetch_sequencer
// Directed scenarios with literal expectations, then randomized traffic against a behavioural model.
module tb_fetch_sequencer;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] TV = 32'h0000_0004;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        retire = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_target = 32'd0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        misalign_trap;
  logic        fetch_err;
  logic [31:0] instret;

  fetch_sequencer #(.RESET_VECTOR(RV), .TRAP_VECTOR(TV), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .retire(retire), .redirect(redirect), .redirect_target(redirect_target),
    .misalign_trap(misalign_trap), .fetch_err(fetch_err), .instret(instret)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: what the outputs must be after the next rising edge.
  bit          m_boot, m_req, m_valid, m_mis, m_err;
  int          m_wait, m_lat;
  logic [31:0] m_pc, m_instr, m_instr_pc, m_instret;

  bit          c_reset = 1'b1, c_retire = 1'b0, c_redirect = 1'b0, c_force_ack = 1'b0;
  bit          c_rand_rdata = 1'b1;
  logic [31:0] c_target = 32'd0, c_rdata = 32'd0;
  int          lat_policy = 0;

  logic [31:0] req_addr_q[$];
  int          req_cyc_q[$];
  int          err_cyc_q[$];
  int          mis_cnt = 0, req_run = 0, last_req_len = 0;
  bit          prev_req = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] qa(input int i);
    if (i < req_addr_q.size()) return req_addr_q[i];
    return 32'hDEAD_DEAD;
  endfunction

  function automatic int pick_lat();
    int r;
    if (lat_policy >= 0) return lat_policy;
    r = int'($urandom_range(0, 19));
    if (r < 10) return r % 4;
    if (r < 16) return int'($urandom_range(4, TO - 1));
    return 99;
  endfunction

  task automatic model_reset();
    m_boot = 1'b1; m_req = 1'b0; m_valid = 1'b0; m_mis = 1'b0; m_err = 1'b0;
    m_wait = 0; m_lat = 0;
    m_pc = RV; m_instr = 32'd0; m_instr_pc = 32'd0; m_instret = 32'd0;
  endtask

  task automatic start_fetch();
    m_req = 1'b1; m_wait = 0; m_lat = pick_lat();
  endtask

  task automatic clr();
    req_addr_q.delete(); req_cyc_q.delete(); err_cyc_q.delete(); mis_cnt = 0;
  endtask

  task automatic compare();
    chk("imem_req", 32'(imem_req), 32'(m_req));
    chk("imem_addr", imem_addr, m_pc);
    chk("instr_valid", 32'(instr_valid), 32'(m_valid));
    chk("instr", instr, m_instr);
    chk("instr_pc", instr_pc, m_instr_pc);
    chk("instret", instret, m_instret);
    chk("misalign_trap", 32'(misalign_trap), 32'(m_mis));
    chk("fetch_err", 32'(fetch_err), 32'(m_err));
    if (imem_req && !prev_req) begin
      req_addr_q.push_back(imem_addr);
      req_cyc_q.push_back(cyc);
    end
    if (imem_req) req_run++;
    else if (prev_req) begin
      last_req_len = req_run;
      req_run = 0;
    end
    if (fetch_err) err_cyc_q.push_back(cyc);
    if (misalign_trap) mis_cnt++;
    prev_req = imem_req;
  endtask

  // Compare on the falling edge, then drive inputs and advance the model past the next rising edge.
  task automatic step();
    bit was_trap;
    @(negedge clk);
    cyc++;
    compare();
    reset           = c_reset;
    imem_ack        = (m_req && (m_wait == m_lat)) || c_force_ack;
    imem_rdata      = (c_rand_rdata || !imem_ack) ? $urandom : c_rdata;
    retire          = c_retire;
    redirect        = c_redirect;
    redirect_target = c_target;
    was_trap = m_mis || m_err;
    m_mis = 1'b0;
    m_err = 1'b0;
    if (c_reset) model_reset();
    else if (m_boot) begin
      m_boot = 1'b0;
      start_fetch();
    end else if (m_req) begin
      if (imem_ack) begin
        m_instr = imem_rdata; m_instr_pc = m_pc; m_req = 1'b0; m_valid = 1'b1;
      end else if (m_wait == TO - 1) begin
        m_req = 1'b0; m_err = 1'b1; m_pc = TV;
      end else m_wait++;
    end else if (m_valid) begin
      if (retire) begin
        m_instret = m_instret + 32'd1;
        m_valid = 1'b0;
        if (redirect && redirect_target[1:0] != 2'b00) begin
          m_mis = 1'b1; m_pc = TV;
        end else begin
          m_pc = redirect ? redirect_target : m_pc + 32'd4;
          start_fetch();
        end
      end
    end else if (was_trap) start_fetch();
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!m_valid && n < 60) begin
      step();
      n++;
    end
    if (!m_valid) begin
      checks++; errors++;
      $display("FAIL wait_valid cyc=%0d actual=no_instruction required=instruction", cyc);
    end
  endtask

  task automatic retire_one(input bit redir, input logic [31:0] target);
    wait_valid();
    c_retire = 1'b1; c_redirect = redir; c_target = target;
    step();
    c_retire = 1'b0; c_redirect = 1'b0;
  endtask

  initial begin
    int d;
    model_reset();
    // Zero-wait memory, immediate retire
    step(); step();
    clr();
    c_reset = 1'b0; lat_policy = 0;
    repeat (4) retire_one(1'b0, 32'd0);
    step(); step();
    chk("A_addr0", qa(0), 32'h0);
    chk("A_addr1", qa(1), 32'h4);
    chk("A_addr2", qa(2), 32'h8);
    chk("A_addr3", qa(3), 32'hC);
    d = (req_cyc_q.size() > 1) ? req_cyc_q[1] - req_cyc_q[0] : -1;
    chk("A_fetch_period", 32'(d), 32'd2);
    chk("A_instret", instret, 32'd4);

    // Three-cycle ack latency
    lat_policy = 2; c_rand_rdata = 1'b0; c_rdata = 32'h1234_5678;
    retire_one(1'b0, 32'd0);
    wait_valid(); step();
    chk("B_req_len", 32'(last_req_len), 32'd3);
    chk("B_instr", instr, 32'h1234_5678);
    chk("B_instr_pc", instr_pc, 32'h14);
    chk("B_no_err", 32'(err_cyc_q.size()), 32'd0);

    // Aligned and misaligned redirects
    lat_policy = 0; c_rand_rdata = 1'b1;
    clr();
    retire_one(1'b1, 32'h0000_0100);
    step(); step(); step();
    chk("C_redirect_addr", qa(0), 32'h100);
    clr();
    retire_one(1'b1, 32'h0000_0102);
    step(); step(); step();
    chk("C_misalign_pulses", 32'(mis_cnt), 32'd1);
    chk("C_trap_addr", qa(0), 32'h4);
    chk("C_instret", instret, 32'd7);

    // Memory never acks
    lat_policy = 99;
    clr();
    retire_one(1'b0, 32'd0);
    lat_policy = 0;
    repeat (20) step();
    chk("D_err_pulses", 32'(err_cyc_q.size()), 32'd1);
    d = (err_cyc_q.size() > 0 && req_cyc_q.size() > 0) ? err_cyc_q[0] - req_cyc_q[0] : -1;
    chk("D_err_delay", 32'(d), 32'd16);
    chk("D_resume_addr", qa(1), 32'h4);

    // PC wrap and a stalled core
    retire_one(1'b1, 32'hFFFF_FFFC);
    wait_valid();
    clr();
    retire_one(1'b0, 32'd0);
    step(); step();
    chk("E_wrap_addr", qa(0), 32'h0);
    chk("E_wrap_pc", instr_pc, 32'h0);
    clr();
    repeat (5) step();
    chk("E_no_fetch", 32'(req_addr_q.size()), 32'd0);
    chk("E_valid_held", 32'(instr_valid), 32'd1);

    // Reset during an outstanding fetch with a coincident ack
    lat_policy = 99;
    retire_one(1'b0, 32'd0);
    step(); step();
    c_reset = 1'b1; c_force_ack = 1'b1;
    step();
    c_force_ack = 1'b0;
    step();
    chk("F_instr", instr, 32'h0);
    chk("F_instret", instret, 32'h0);
    chk("F_pc", imem_addr, RV);
    chk("F_req", 32'(imem_req), 32'd0);
    lat_policy = 0; c_reset = 1'b0;
    clr();
    step(); step(); step();
    chk("F_restart_addr", qa(0), RV);

    // Randomized traffic
    lat_policy = -1;
    for (int i = 0; i < 3000; i++) begin
      c_retire   = ($urandom_range(0, 9) < 6);
      c_redirect = ($urandom_range(0, 9) < 3);
      c_target   = $urandom & 32'h0000_0FFC;
      if ($urandom_range(0, 3) == 0) c_target[1:0] = 2'($urandom_range(1, 3));
      c_reset    = ($urandom_range(0, 499) == 0);
      step();
    end
    c_reset = 1'b0; c_retire = 1'b0; c_redirect = 1'b0;
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
